// File: rtl/btb_pkg.sv
// btb_pkg: shared types and constants for the branch target buffer.
// The entry struct is sized for the widest legal configuration (2 entries,
// 4-bit counters); narrower builds keep the unused upper bits at zero.
package btb_pkg;

  localparam int PC_INC    = 4;
  localparam int STAT_W    = 32;

  // Widest tag occurs with the smallest table (ENTRIES = 2, IDX_W = 1).
  localparam int MAX_TAG_W = 29;
  // Widest supported saturating counter.
  localparam int MAX_CNT_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [MAX_CNT_W-1:0] counter;
  } btb_entry_t;

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// sat_counter: one-step saturating up/down counter used to train the
// direction predictor of each BTB entry. inc and dec together hold the value.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_next
);

  // Move one step towards taken or not-taken, sticking at the end stops.
  always_comb begin
    cnt_next = cnt;
    if (inc && !dec) begin
      if (cnt != '1) cnt_next = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters. Lookup is combinational (IF stage),
// training and misprediction detection come from the MEM stage.
// Optional feature: define BTB_PREDICTOR_STATS_EN to build the 32-bit
// lookup / mispredict performance counters; otherwise the stat ports read 0.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,

  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  input  logic        update_pred_taken_i,
  input  logic [31:0] update_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,

  input  logic        flush_i,

  output logic [31:0] stat_lookups_o,
  output logic [31:0] stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Counter value given to a freshly allocated entry: weakly taken.
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  btb_entry_t entries_q [ENTRIES];

  // ---------------------------------------------------------------------
  // Lookup path
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_entry;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx   = lookup_pc_i[IDX_W+1:2];
  assign lk_tag   = lookup_pc_i[31:IDX_W+2];
  assign lk_entry = entries_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == MAX_TAG_W'(lk_tag));
  assign lk_taken = lk_hit && lk_entry.counter[CNT_W-1];

  assign pred_hit_o    = lookup_valid_i && lk_hit;
  assign pred_taken_o  = lookup_valid_i && lk_taken;
  assign pred_target_o = pred_taken_o ? lk_entry.target
                                      : lookup_pc_i + 32'(PC_INC);

  // ---------------------------------------------------------------------
  // Resolution path: misprediction detection and redirect
  // ---------------------------------------------------------------------
  logic mispredict;

  assign mispredict = update_valid_i &&
                      ((update_taken_i != update_pred_taken_i) ||
                       (update_taken_i && (update_target_i != update_pred_target_i)));

  assign mispredict_o  = mispredict;
  assign redirect_pc_o = !mispredict    ? 32'd0 :
                         update_taken_i ? update_target_i
                                        : update_pc_i + 32'(PC_INC);

  // ---------------------------------------------------------------------
  // Training path
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       up_entry;
  logic             up_hit;
  logic [CNT_W-1:0] cnt_next;

  assign up_idx   = update_pc_i[IDX_W+1:2];
  assign up_tag   = update_pc_i[31:IDX_W+2];
  assign up_entry = entries_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == MAX_TAG_W'(up_tag));

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .cnt      (up_entry.counter[CNT_W-1:0]),
    .inc      (update_taken_i),
    .dec      (!update_taken_i),
    .cnt_next (cnt_next)
  );

  // Entry array: reset clears everything, flush drops only the valid bits
  // and beats any concurrent training; a hit retrains the counter (and
  // target when taken), a taken miss evicts the occupant of the index.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (update_valid_i) begin
      if (up_hit) begin
        entries_q[up_idx].counter <= MAX_CNT_W'(cnt_next);
        if (update_taken_i) begin
          entries_q[up_idx].target <= update_target_i;
        end
      end else if (update_taken_i) begin
        entries_q[up_idx] <= '{valid:   1'b1,
                               tag:     MAX_TAG_W'(up_tag),
                               target:  update_target_i,
                               counter: MAX_CNT_W'(CNT_WEAK)};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
`ifdef BTB_PREDICTOR_STATS_EN
  logic [STAT_W-1:0] lookups_q;
  logic [STAT_W-1:0] mispred_q;

  // Free-running wrapping event counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (lookup_valid_i) lookups_q <= lookups_q + 1'b1;
      if (mispredict)     mispred_q <= mispred_q + 1'b1;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_mispred_o = mispred_q;
`else
  assign stat_lookups_o = 32'd0;
  assign stat_mispred_o = 32'd0;
`endif

  // Bits that carry no information for this configuration: the byte offset
  // of the PCs, the spare counter bits and the target read on the update port.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0],
                         lk_entry.counter, up_entry.counter, up_entry.target};

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of direct-mapped entries (power of two, 2..1024).
REQ-002 SHALL have parameter CNT_W, default 2, saturating-counter width in bits (1..4).
REQ-003 SHALL derive localparams IDX_W = log2(ENTRIES) and TAG_W = 30 - IDX_W; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-004 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 lookup_valid_i  in  1  IF-stage lookup request.
REQ-007 lookup_pc_i  in  32  PC of the fetched instruction.
REQ-008 pred_hit_o  out  1  valid entry with matching tag.
REQ-009 pred_taken_o  out  1  hit and counter MSB = 1.
REQ-010 pred_target_o  out  32  stored target when pred_taken_o = 1, else lookup_pc_i+4.
REQ-011 update_valid_i  in  1  resolved branch from MEM stage.
REQ-012 update_pc_i  in  32  PC of the resolved branch.
REQ-013 update_taken_i  in  1  actual direction.
REQ-014 update_target_i  in  32  actual taken target.
REQ-015 update_pred_taken_i / update_pred_target_i  in  1 / 32  prediction carried down the pipe.
REQ-016 mispredict_o  out  1  redirect request; redirect_pc_o  out  32  correct next PC.
REQ-017 flush_i  in  1  invalidate all entries.
REQ-018 stat_lookups_o / stat_mispred_o  out  32 / 32  performance counters.

Function
REQ-019 Lookup outputs SHALL be combinational from lookup_pc_i and current array state (zero-cycle latency); with lookup_valid_i = 0 all pred_* SHALL be 0 except pred_target_o = lookup_pc_i+4.
REQ-020 mispredict_o SHALL be combinational: update_valid_i and (update_taken_i != update_pred_taken_i or (update_taken_i and update_target_i != update_pred_target_i)).
REQ-021 redirect_pc_o SHALL equal update_target_i if update_taken_i, else update_pc_i+4; 0 when mispredict_o = 0.
REQ-022 On update_valid_i with tag hit: counter SHALL increment (saturate at 2^CNT_W-1) if taken, decrement (saturate at 0) if not; target SHALL be overwritten with update_target_i only when taken.
REQ-023 On update_valid_i with miss and taken: entry SHALL be allocated (valid=1, tag, target) with counter = 2^(CNT_W-1) (weakly taken), replacing any occupant.
REQ-024 On update_valid_i with miss and not taken: no array change.
REQ-025 Array writes SHALL take effect at the rising edge ending the update cycle; a same-cycle lookup of the same index SHALL see pre-update contents (no bypass).
REQ-026 flush_i SHALL clear all valid bits at the next edge; flush_i and update_valid_i together: flush wins, update dropped; mispredict_o still reported.
REQ-027 With CNT_W = 1 behaviour SHALL reduce to one-bit last-outcome prediction.

Reset
REQ-028 rst_ni = 0 at a rising edge SHALL clear every valid bit, counter, tag, target and stat counter; reset SHALL take priority over flush and update.
REQ-029 Outputs are combinational; during and after reset pred_hit_o = pred_taken_o = 0 and stat outputs = 0 until new activity.

Configuration
REQ-030 Macro BTB_PREDICTOR_STATS_EN defined: stat_lookups_o counts cycles with lookup_valid_i, stat_mispred_o counts cycles with mispredict_o; both 32-bit wrapping, unaffected by flush_i.
REQ-031 Macro undefined: stat ports SHALL exist and be tied to 0, no counter registers instantiated.

Structure
REQ-032 Package btb_pkg SHALL hold the entry struct typedef (valid, tag, target, counter) parametrised via widths, and constants PC_INC = 4, STAT_W = 32.
REQ-033 One sub-module sat_counter (parameter CNT_W; inputs cnt, inc, dec; output next value) SHALL implement saturating update.

Verification
REQ-034 Reset, then lookup 0x0000_0100 -> pred_hit_o = 0, pred_target_o = 0x0000_0104.
REQ-035 Update pc 0x100 taken target 0x200, pred_taken 0 -> mispredict_o = 1, redirect 0x200; next-cycle lookup 0x100 -> hit, taken, target 0x200, counter = 2.
REQ-036 CNT_W = 2: three taken updates at 0x100 then one not-taken -> counter 3 (saturated) then 2, prediction still taken; second not-taken -> 1, predict not-taken, target 0x104.
REQ-037 Alias: ENTRIES = 64, allocate 0x100 then taken update 0x10100 (same index) -> 0x100 lookup misses, 0x10100 hits.
REQ-038 flush_i with concurrent update at 0x300 -> all lookups miss next cycle, 0x300 not allocated.
REQ-039 With BTB_PREDICTOR_STATS_EN: 10 lookups, 3 mispredicts -> stat_lookups_o = 10, stat_mispred_o = 3; without macro both 0.
